user_exmem_ctrl: RTL and testbench
==================================

USER_EXMEM_CTRL -- requirements
Module: user_exmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, meaning word-address width; DEPTH = 2**ADDR_W 32-bit words.
REQ-002 Parameter MEM_BASE, default 32'h3800_0000, meaning memory window base (byte address).
REQ-003 Parameter CSR_BASE, default 32'h3100_0000, meaning CSR window base.
REQ-004 Parameter DEF_DELAY, default 10, meaning reset value of the programmable wait-state count (0..255).
REQ-005 Port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 Port wb_rstn_i  in  1  reset, synchronous, active-low.
REQ-007 Ports wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write-enable.
REQ-008 Port wbs_sel_i  in  4  byte enables; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-009 Port wbs_ack_o  out  1  registered acknowledge; wbs_dat_o  out  32  registered read data.
REQ-010 Port irq_o  out  1  level, high while STATUS.err = 1 and CTRL.irq_en = 1.

Function
REQ-011 Memory hit: cyc&stb and adr[31:24] == MEM_BASE[31:24]; CSR hit: cyc&stb and adr[31:8] == CSR_BASE[31:8]; any other address: ignored, no ack.
REQ-012 FSM states IDLE, WAIT, ACK; IDLE->WAIT on any hit (edge k), latching adr, we, sel, dat and delay D = CTRL.delay.
REQ-013 WAIT counts D cycles (D=0: leaves after 1 cycle) then ->ACK; wbs_ack_o high exactly one cycle, beginning at edge k+1+D; ACK->IDLE unconditionally.
REQ-014 A strobe still high during the ACK cycle is not a new request; next acceptance no earlier than edge k+2+D.
REQ-015 Memory write: exmem_bram enable and byte-write mask (sel) asserted for exactly one cycle at acceptance, never repeated.
REQ-016 Memory read: bram read issued at acceptance, result captured internally, driven on wbs_dat_o only during the ACK cycle; wbs_dat_o = 0 in all other cycles.
REQ-017 Memory offset = adr - MEM_BASE; word index = offset[ADDR_W+1:2]; offset >= DEPTH*4 is out of range: no bram access, still acked, read data 0, STATUS.err set.
REQ-018 CSR 0x00 CTRL RW: [7:0] delay, [8] irq_en; other bits read 0.
REQ-019 CSR 0x04 STATUS: [0] err sticky, write-1-to-clear; [1] busy (FSM != IDLE, reads 1 during a CSR access).
REQ-020 CSR 0x08 ACC_CNT: completed memory acks (in-range and out-of-range), 32-bit saturating at 32'hFFFF_FFFF; any write clears to 0.
REQ-021 CSR accesses obey REQ-012..REQ-014 with the same delay; unmapped CSR offsets: writes ignored, reads 0.
REQ-022 cyc_i falling while in WAIT: abort to IDLE next edge, no ack, ACC_CNT unchanged; a write already committed at acceptance stays committed.
REQ-023 CTRL.delay written while idle takes effect from the next accepted transaction only.

Reset
REQ-024 wb_rstn_i low at an edge: FSM->IDLE, wait counter 0, wbs_ack_o 0, wbs_dat_o 0, CTRL = {irq_en 0, delay DEF_DELAY}, STATUS.err 0, ACC_CNT 0, irq_o 0.
REQ-025 Reset mid-transaction drops it with no ack; memory contents are not cleared.

Structure
REQ-026 Package exmem_pkg holds the state enum, CSR offsets (0x00/0x04/0x08), field positions, and DEF_DELAY default.
REQ-027 Sub-module exmem_bram: 1RW, DEPTH x 32, byte-write, one-cycle synchronous read, parameter ADDR_W.

Verification
REQ-028 Write 0xDEAD_BEEF to 0x3800_0010, sel 4'hF, delay 10, then read it -> both acks exactly 11 cycles after acceptance, read data 0xDEAD_BEEF, single-cycle ack.
REQ-029 Program CTRL.delay=0, write sel 4'b0011 data 0x1234_5678 over 0xFFFF_FFFF at word 3 -> ack 1 cycle after acceptance; read returns 0xFFFF_5678.
REQ-030 Read 0x3800_0000 + DEPTH*4 with irq_en=1 -> acked, data 0, STATUS.err=1, irq_o=1; write 1 to STATUS[0] -> err 0, irq_o 0.
REQ-031 Hold stb/cyc high through 3 back-to-back reads -> exactly 3 one-cycle acks, each separated by >= 1 idle cycle, ACC_CNT = 3.
REQ-032 Drop cyc 2 cycles into a delay-10 read, then assert wb_rstn_i low mid-wait on a second read -> no ack either time, ACC_CNT unchanged, CTRL.delay back to 10.

Source files
------------

// File: rtl/exmem_pkg.sv
// Shared types and constants for the Wishbone external-memory controller.
// Holds the FSM encoding, CSR map and CTRL/STATUS field positions.
package exmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [7:0] CSR_CTRL    = 8'h00;
  localparam logic [7:0] CSR_STATUS  = 8'h04;
  localparam logic [7:0] CSR_ACC_CNT = 8'h08;

  localparam int CTRL_DELAY_LSB = 0;
  localparam int CTRL_DELAY_W   = 8;
  localparam int CTRL_IRQ_EN    = 8;
  localparam int STATUS_ERR     = 0;
  localparam int STATUS_BUSY    = 1;

  localparam int unsigned DEF_DELAY_DFLT = 10;

endpackage

// File: rtl/exmem_bram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered
// read port; the read register holds its value until the next enabled access.
module exmem_bram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/user_exmem_ctrl.sv
// Wishbone slave fronting a byte-writable RAM plus a small CSR block, with a
// programmable number of wait states inserted before every acknowledge.
module user_exmem_ctrl
  import exmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] MEM_BASE  = 32'h3800_0000,
  parameter logic [31:0] CSR_BASE  = 32'h3100_0000,
  parameter int unsigned DEF_DELAY = DEF_DELAY_DFLT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  state_t      state, state_nxt;
  logic [7:0]  cnt, delay, lat_off;
  logic        irq_en, err, lat_we, lat_mem, lat_oor;
  logic [8:0]  lat_dat;
  logic [31:0] acc_cnt, mem_off, csr_rd, bram_q;
  logic        hit_mem, hit_csr, mem_oor, accept, done, bram_en;

  assign hit_mem = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:24] == MEM_BASE[31:24]);
  assign hit_csr = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == CSR_BASE[31:8]);
  assign mem_off = wbs_adr_i - MEM_BASE;
  assign mem_oor = (mem_off >> (ADDR_W + 2)) != 32'd0;
  assign accept  = (state == S_IDLE) && (hit_mem || hit_csr);
  assign done    = (state == S_WAIT) && wbs_cyc_i && (cnt == 8'd0);
  assign irq_o   = err && irq_en;

  // RAM is touched only on the acceptance edge, so writes commit exactly once
  // and the read register keeps the fetched word until the ack.
  assign bram_en = wb_rstn_i && accept && hit_mem && !mem_oor;

  exmem_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk  (wb_clk_i),
    .en   (bram_en),
    .we   (wbs_we_i ? wbs_sel_i : 4'b0000),
    .addr (mem_off[ADDR_W+1:2]),
    .wdata(wbs_dat_i),
    .rdata(bram_q)
  );

  always_comb begin
    csr_rd = '0;
    case (lat_off)
      CSR_CTRL: begin
        csr_rd[CTRL_DELAY_LSB +: CTRL_DELAY_W] = delay;
        csr_rd[CTRL_IRQ_EN]                    = irq_en;
      end
      CSR_STATUS: begin
        csr_rd[STATUS_ERR]  = err;
        csr_rd[STATUS_BUSY] = (state != S_IDLE);
      end
      CSR_ACC_CNT: csr_rd = acc_cnt;
      default:     csr_rd = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!wbs_cyc_i)         state_nxt = S_IDLE;
        else if (cnt == 8'd0)   state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      delay     <= 8'(DEF_DELAY);
      irq_en    <= 1'b0;
      err       <= 1'b0;
      acc_cnt   <= '0;
      lat_we    <= 1'b0;
      lat_mem   <= 1'b0;
      lat_oor   <= 1'b0;
      lat_off   <= '0;
      lat_dat   <= '0;
    end else begin
      state     <= state_nxt;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      if (accept) begin
        cnt     <= delay;
        lat_we  <= wbs_we_i;
        lat_mem <= hit_mem;
        lat_oor <= hit_mem && mem_oor;
        lat_off <= wbs_adr_i[7:0];
        lat_dat <= wbs_dat_i[8:0];
      end else if (state == S_WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      // CSR side effects land with the ack so an aborted access leaves no trace.
      if (done) begin
        wbs_ack_o <= 1'b1;
        if (lat_mem) begin
          if (!lat_we && !lat_oor) wbs_dat_o <= bram_q;
          if (lat_oor) err <= 1'b1;
          if (acc_cnt != '1) acc_cnt <= acc_cnt + 32'd1;
        end else if (!lat_we) begin
          wbs_dat_o <= csr_rd;
        end else begin
          case (lat_off)
            CSR_CTRL: begin
              delay  <= lat_dat[CTRL_DELAY_LSB +: CTRL_DELAY_W];
              irq_en <= lat_dat[CTRL_IRQ_EN];
            end
            CSR_STATUS:  if (lat_dat[STATUS_ERR]) err <= 1'b0;
            CSR_ACC_CNT: acc_cnt <= '0;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_user_exmem_ctrl.sv
// Bench for user_exmem_ctrl: a transaction-level model predicts ack timing,
// read data and irq every cycle; directed scenarios pin literal expectations.
module tb_user_exmem_ctrl;

  localparam int          ADDR_W   = 10;
  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] MEM_BASE = 32'h3800_0000;
  localparam logic [31:0] CSR_BASE = 32'h3100_0000;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, irq;
  logic [31:0] rdat;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  user_exmem_ctrl #(
    .ADDR_W(ADDR_W), .MEM_BASE(MEM_BASE), .CSR_BASE(CSR_BASE), .DEF_DELAY(10)
  ) dut (
    .wb_clk_i (clk),
    .wb_rstn_i(rstn),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .irq_o    (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mmem [DEPTH];
  int          ecnt = 0, due = 0, next_ok = 0, t_idx = 0;
  bit          pend = 0, t_mem = 0, t_we = 0, t_oor = 0, chk_en = 0;
  logic [7:0]  t_off = '0, m_delay = 8'd10;
  logic [31:0] t_dat = '0, m_acc = '0, exp_dat = '0;
  bit          m_irq_en = 0, m_err = 0, exp_ack = 0;

  always @(posedge clk) begin : model
    logic        mh, ch;
    logic [31:0] off;
    ecnt++;
    exp_ack = 0;
    exp_dat = '0;
    mh  = cyc && stb && (adr[31:24] == MEM_BASE[31:24]);
    ch  = cyc && stb && (adr[31:8] == CSR_BASE[31:8]);
    off = adr - MEM_BASE;
    if (!rstn) begin
      pend = 0; next_ok = ecnt + 1; chk_en = 1;
      m_delay = 8'd10; m_irq_en = 0; m_err = 0; m_acc = '0;
    end else if (pend) begin
      if (!cyc) begin
        pend = 0; next_ok = ecnt + 1;
      end else if (ecnt == due) begin
        exp_ack = 1; pend = 0; next_ok = ecnt + 2;
        if (t_mem) begin
          if (t_oor) m_err = 1;
          else if (!t_we) exp_dat = mmem[t_idx];
          if (m_acc != 32'hFFFF_FFFF) m_acc = m_acc + 32'd1;
        end else if (!t_we) begin
          case (t_off)
            8'h00:   exp_dat = {23'd0, m_irq_en, m_delay};
            8'h04:   exp_dat = {30'd0, 1'b1, m_err};
            8'h08:   exp_dat = m_acc;
            default: exp_dat = '0;
          endcase
        end else begin
          case (t_off)
            8'h00: begin m_delay = t_dat[7:0]; m_irq_en = t_dat[8]; end
            8'h04: if (t_dat[0]) m_err = 0;
            8'h08: m_acc = '0;
            default: ;
          endcase
        end
      end
    end else if (ecnt >= next_ok && (mh || ch)) begin
      pend  = 1;
      due   = ecnt + 1 + int'(m_delay);
      t_mem = mh; t_we = we; t_off = adr[7:0]; t_dat = wdat;
      t_oor = mh && (off >= 32'(DEPTH * 4));
      t_idx = int'(off >> 2);
      if (mh && !t_oor && we)
        for (int b = 0; b < 4; b++)
          if (sel[b]) mmem[t_idx][8*b +: 8] = wdat[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ack", 32'(ack), 32'(exp_ack));
      check("cyc_dat", rdat, exp_dat);
      check("cyc_irq", 32'(irq), 32'(m_err & m_irq_en));
    end
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r, output int lat);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    lat = -1; r = '0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (ack) begin lat = i - 1; r = rdat; break; end
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic rnd_txn();
    int          k, abort_at, got;
    logic        hit;
    logic [31:0] a, d;
    k = int'($urandom_range(0, 9));
    d = $urandom;
    case (k)
      0, 1, 2, 3: a = MEM_BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      4: a = MEM_BASE + 32'(DEPTH * 4) + ($urandom_range(0, 1023) << 2);
      5: begin
        a = CSR_BASE;
        d = (d & 32'hFFFF_FE00) | ($urandom_range(0, 1) << 8) | $urandom_range(0, 3);
      end
      6: a = CSR_BASE + 32'h4;
      7: a = CSR_BASE + ($urandom_range(2, 5) << 2);
      8: a = 32'h3200_0000 + $urandom_range(0, 255);
      default: a = CSR_BASE + 32'h100;
    endcase
    hit = (k <= 7);
    abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1'($urandom_range(0, 1)); sel = 4'($urandom_range(1, 15));
    adr = a; wdat = d;
    got = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack) begin got = 1; break; end
      if (i == abort_at || (!hit && i == 3)) break;
    end
    cyc = 0; stb = 0; we = 0;
    if (hit && abort_at == 0) check("rnd_acked", 32'(got), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int          lat, nack, last;
    bit          gap_ok;

    rstn = 0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rstn = 1;
    xfer(0, CSR_BASE, '0, 4'hF, r, lat);          check("ctrl_rst", r, 32'h0000_000A);
    xfer(0, CSR_BASE + 32'h8, '0, 4'hF, r, lat);  check("acc_rst", r, 32'd0);

    // delay 10: write then read back
    xfer(1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, r, lat); check("w_lat_d10", 32'(lat), 32'd11);
    xfer(0, 32'h3800_0010, '0, 4'hF, r, lat);            check("r_lat_d10", 32'(lat), 32'd11);
    check("r_dat_d10", r, 32'hDEAD_BEEF);
    @(negedge clk); check("ack_1cyc", 32'(ack), 32'd0);

    // delay 0 with partial byte write
    xfer(1, CSR_BASE, 32'h0, 4'hF, r, lat);               check("ctrl_w_lat", 32'(lat), 32'd11);
    xfer(1, 32'h3800_000C, 32'hFFFF_FFFF, 4'hF, r, lat);  check("w_lat_d0", 32'(lat), 32'd1);
    xfer(1, 32'h3800_000C, 32'h1234_5678, 4'b0011, r, lat);
    xfer(0, 32'h3800_000C, '0, 4'hF, r, lat);             check("r_lat_d0", 32'(lat), 32'd1);
    check("r_dat_sel", r, 32'hFFFF_5678);
    check("model_w3", mmem[3], 32'hFFFF_5678);

    // out-of-range access raises err / irq, W1C clears it
    xfer(1, CSR_BASE, 32'h100, 4'hF, r, lat);
    xfer(0, MEM_BASE + 32'(DEPTH * 4), '0, 4'hF, r, lat);
    check("oor_acked", 32'(lat), 32'd1);
    check("oor_dat", r, 32'd0);
    check("irq_set", 32'(irq), 32'd1);
    xfer(0, CSR_BASE + 32'h4, '0, 4'hF, r, lat);  check("status_err", r, 32'h3);
    xfer(1, CSR_BASE + 32'h4, 32'h1, 4'hF, r, lat); check("irq_clr", 32'(irq), 32'd0);
    xfer(0, CSR_BASE + 32'h4, '0, 4'hF, r, lat);  check("status_clr", r, 32'h2);

    // strobe held through three back-to-back reads
    xfer(1, CSR_BASE, 32'h2, 4'hF, r, lat);
    xfer(1, CSR_BASE + 32'h8, 32'h0, 4'hF, r, lat);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h3800_0010; sel = 4'hF;
    nack = 0; last = -10; gap_ok = 1;
    for (int i = 0; i < 100 && nack < 3; i++) begin
      @(negedge clk);
      if (ack) begin
        if (nack > 0 && i - last < 2) gap_ok = 0;
        last = i; nack++;
      end
    end
    cyc = 0; stb = 0;
    check("b2b_acks", 32'(nack), 32'd3);
    check("b2b_gap", 32'(gap_ok), 32'd1);
    check("model_acc", m_acc, 32'd3);
    xfer(0, CSR_BASE + 32'h8, '0, 4'hF, r, lat);  check("b2b_acc", r, 32'd3);

    // abort by dropping cyc, then by reset
    xfer(1, CSR_BASE, 32'h0A, 4'hF, r, lat);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h3800_0010;
    nack = 0;
    repeat (2) begin @(negedge clk); if (ack) nack++; end
    cyc = 0; stb = 0;
    repeat (15) begin @(negedge clk); if (ack) nack++; end
    check("abort_noack", 32'(nack), 32'd0);
    xfer(0, CSR_BASE + 32'h8, '0, 4'hF, r, lat);  check("abort_acc", r, 32'd3);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h3800_0010;
    nack = 0;
    repeat (4) begin @(negedge clk); if (ack) nack++; end
    rstn = 0;
    @(negedge clk);
    rstn = 1; cyc = 0; stb = 0;
    repeat (15) begin @(negedge clk); if (ack) nack++; end
    check("rst_noack", 32'(nack), 32'd0);
    xfer(0, CSR_BASE, '0, 4'hF, r, lat);          check("rst_delay", r, 32'h0000_000A);
    xfer(0, CSR_BASE + 32'h8, '0, 4'hF, r, lat);  check("rst_acc", r, 32'd0);

    // randomized traffic over a preloaded region
    xfer(1, CSR_BASE, 32'h0, 4'hF, r, lat);
    for (int w = 0; w < 64; w++) xfer(1, MEM_BASE + 32'(w * 4), $urandom, 4'hF, r, lat);
    repeat (250) rnd_txn();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
